// File: rtl/width_conv_fifo_pkg.sv
// Shared types and width helpers for the width-converting FIFO.
package width_conv_fifo_pkg;

    typedef enum {STD, FWFT} fifo_mode_e;

    // Wide-slot pointer width: slot index plus wrap bit.
    function automatic int ptr_w(input int depth);
        return $clog2(depth) + 1;
    endfunction

    // Narrow-word count width.
    function automatic int cnt_w(input int depth, input int ratio);
        return $clog2(depth * ratio) + 1;
    endfunction

    // Width of the narrow sub-index within a wide slot (at least one bit).
    function automatic int sub_w(input int ratio);
        return (ratio > 1) ? $clog2(ratio) : 1;
    endfunction

endpackage

// File: rtl/width_conv_fifo_if.sv
// Handshake and status bundle between a producer/consumer and the FIFO.
interface width_conv_fifo_if
    import width_conv_fifo_pkg::*;
#(
    parameter int RD_W     = 3,
    parameter int RATIO    = 2,
    parameter int WR_DEPTH = 16
);
    localparam int WR_W = RD_W * RATIO;
    localparam int WCW  = ptr_w(WR_DEPTH);
    localparam int RCW  = cnt_w(WR_DEPTH, RATIO);

    logic [WR_W-1:0] din;
    logic            wr_en;
    logic            rd_en;
    logic [RD_W-1:0] dout;
    logic            valid;
    logic            full;
    logic            empty;
    logic            wr_ack;
    logic            overflow;
    logic            underflow;
    logic [WCW-1:0]  wr_count;
    logic [RCW-1:0]  rd_count;

    modport master (
        output din, wr_en, rd_en,
        input  dout, valid, full, empty, wr_ack, overflow, underflow,
               wr_count, rd_count
    );

    modport slave (
        input  din, wr_en, rd_en,
        output dout, valid, full, empty, wr_ack, overflow, underflow,
               wr_count, rd_count
    );
endinterface

// File: rtl/width_conv_fifo_ram.sv
// Register array: one synchronous write port, asynchronous read by wide index.
module wcf_ram #(
    parameter int DEPTH = 16,
    parameter int WIDTH = 6
) (
    input  logic                     clk,
    input  logic                     we,
    input  logic [$clog2(DEPTH)-1:0] waddr,
    input  logic [WIDTH-1:0]         wdata,
    input  logic [$clog2(DEPTH)-1:0] raddr,
    output logic [WIDTH-1:0]         rdata
);
    logic [WIDTH-1:0] mem [DEPTH];

    // Store the wide word; contents are invalidated through the pointers, not cleared.
    always_ff @(posedge clk) begin
        if (we) mem[waddr] <= wdata;
    end

    assign rdata = mem[raddr];
endmodule

// File: rtl/width_conv_fifo.sv
// Wide-in / narrow-out FIFO, MSB slice first, STD or FWFT read mode.
module width_conv_fifo
    import width_conv_fifo_pkg::*;
#(
    parameter int         RD_W     = 3,
    parameter int         RATIO    = 2,
    parameter int         WR_DEPTH = 16,
    parameter fifo_mode_e MODE     = STD
) (
    input logic               clk,
    input logic               rst_n,
    width_conv_fifo_if.slave  bus
);
    localparam int WR_W = RD_W * RATIO;
    localparam int AW   = $clog2(WR_DEPTH);
    localparam int PW   = ptr_w(WR_DEPTH);
    localparam int CW   = cnt_w(WR_DEPTH, RATIO);
    localparam int SW   = sub_w(RATIO);

    // Read pointer is kept as wide index + sub-slot so RATIO need not be a power of two.
    logic [PW-1:0]   wp, rp_w, wdiff;
    logic [SW-1:0]   rp_s;
    logic [CW-1:0]   rd_cnt;
    logic            busy, full_i, empty_i, wr_ok, rd_ok;
    logic [WR_W-1:0] head;
    logic [RD_W-1:0] slice, dout_q;
    logic            valid_q, wr_ack_q, ovf_q, udf_q;

    assign wdiff   = wp - rp_w;
    assign rd_cnt  = CW'(wdiff) * CW'(RATIO) - CW'(rp_s);
    assign full_i  = (wdiff == PW'(WR_DEPTH)) | busy;
    assign empty_i = (rd_cnt == '0);
    assign wr_ok   = bus.wr_en & ~full_i;
    assign rd_ok   = bus.rd_en & ~empty_i;

    wcf_ram #(.DEPTH(WR_DEPTH), .WIDTH(WR_W)) u_ram (
        .clk   (clk),
        .we    (wr_ok),
        .waddr (wp[AW-1:0]),
        .wdata (bus.din),
        .raddr (rp_w[AW-1:0]),
        .rdata (head)
    );

    // Select the head narrow word; sub-slot 0 is the most significant slice.
    always_comb begin
        slice = '0;
        for (int i = 0; i < RATIO; i++) begin
            if (rp_s == SW'(i)) slice = head[(RATIO-1-i)*RD_W +: RD_W];
        end
    end

    // Pointers and reset-busy; busy holds full high until the first edge after release.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wp   <= '0;
            rp_w <= '0;
            rp_s <= '0;
            busy <= 1'b1;
        end else begin
            busy <= 1'b0;
            if (wr_ok) wp <= wp + 1'b1;
            if (rd_ok) begin
                if (rp_s == SW'(RATIO-1)) begin
                    rp_s <= '0;
                    rp_w <= rp_w + 1'b1;
                end else begin
                    rp_s <= rp_s + 1'b1;
                end
            end
        end
    end

    // Registered single-cycle status pulses and the STD-mode output register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ack_q <= 1'b0;
            ovf_q    <= 1'b0;
            udf_q    <= 1'b0;
            valid_q  <= 1'b0;
            dout_q   <= '0;
        end else begin
            wr_ack_q <= wr_ok;
            ovf_q    <= bus.wr_en & full_i;
            udf_q    <= bus.rd_en & empty_i;
            valid_q  <= rd_ok;
            if (rd_ok) dout_q <= slice;
        end
    end

    // FWFT shows the head slice directly; gated to zero when nothing is buffered.
    assign bus.dout      = (MODE == FWFT) ? (empty_i ? '0 : slice) : dout_q;
    assign bus.valid     = (MODE == FWFT) ? ~empty_i : valid_q;
    assign bus.full      = full_i;
    assign bus.empty     = empty_i;
    assign bus.wr_ack    = wr_ack_q;
    assign bus.overflow  = ovf_q;
    assign bus.underflow = udf_q;
    assign bus.wr_count  = wdiff;
    assign bus.rd_count  = rd_cnt;
endmodule
